// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counting timer, the count-down partner of the mod-N up
// counters. A programmed value is counted down to zero, one step per enable
// tick. At expiry a combinational terminal-borrow strobe (tc) is raised, and
// a registered one-cycle done pulse follows on the next cycle. The timer runs
// either one-shot (returns to idle at expiry) or periodic (reloads the last
// loaded value and keeps running). The enable input is normally the terminal
// count of a slower counter, so the timer acts as a timebase consumer.
//
// Parameters
//   W         counter width in bits; largest load value is 2^W-1
//
// Ports
//   clk       clock, every state update on the rising edge
//   reset     asynchronous, active-low reset
//   load      capture load_val into both the count and reload registers
//   load_val  value captured on load
//   start     start counting from idle, or resume from pause
//   stop      pause counting, count held
//   periodic  1 = auto-reload at expiry, 0 = one-shot (looked at only at expiry)
//   enable    count tick, decrements only while running
//   count     current count value
//   busy      high while running or paused
//   tc        terminal borrow: running, enable high and count equal to one
//   done      registered one-cycle pulse after expiry or after a zero-start
// ---------------------------------------------------------------------------
module countdown_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         tc,
  output logic         done
);

  // Three operating modes. PAUSE is kept separate from IDLE so that a
  // resume does not need a fresh load, and so that busy stays high while
  // the count is frozen.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = '0;

  state_t       state;
  state_t       state_next;
  logic [W-1:0] count_next;
  logic [W-1:0] reload;
  logic [W-1:0] reload_next;
  logic         done_next;

  // State, count, reload value and the done pulse are all registered here.
  // The reset is asynchronous so a timer can be killed mid-run without
  // waiting for a clock edge; every register returns to zero / IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= ZERO;
      reload <= ZERO;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      done   <= done_next;
    end
  end

  // Next-state and next-count decision. The controls are resolved in a
  // fixed priority: load beats stop, stop beats start, start beats enable.
  // A load always lands the timer in IDLE with the new value and throws
  // away any expiry that would have happened in the same cycle, which is
  // why done_next is only ever set outside the load branch.
  // In RUN a start has nothing to do, so the enable tick is still honoured.
  // When the count reaches one and a tick arrives, that is the expiry:
  // a one-shot timer parks at zero in IDLE, a periodic timer reloads and
  // keeps running. The count==0 guard in RUN means the counter can never
  // wrap below zero even if that state were somehow reached.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    done_next   = 1'b0;

    if (load) begin
      count_next  = load_val;
      reload_next = load_val;
      state_next  = IDLE;
    end else if (stop) begin
      if (state == RUN) begin
        state_next = PAUSE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count != ZERO) begin
              state_next = RUN;
            end else begin
              done_next = 1'b1;
            end
          end
        end

        PAUSE: begin
          if (start) begin
            state_next = RUN;
          end
        end

        RUN: begin
          if (enable) begin
            if (count == ONE) begin
              done_next = 1'b1;
              if (periodic) begin
                count_next = reload;
              end else begin
                count_next = ZERO;
                state_next = IDLE;
              end
            end else if (count != ZERO) begin
              count_next = count - ONE;
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Status outputs. tc is deliberately combinational so a downstream
  // counter can chain off it in the same cycle as the expiry; done is the
  // registered version and arrives one cycle later.
  always_comb begin
    busy = (state != IDLE);
    tc   = (state == RUN) && enable && (count == ONE);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Bench for countdown_timer. A small behavioural model of the timer is kept
// here and advanced once per clock from the same inputs the DUT sees; each
// scenario task drives its own stimulus and compares DUT outputs to the
// model and to hand-derived constants.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         periodic;
  logic         enable;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the timer: a count, a remembered load value,
  // whether it is running, whether it is paused and the pending done pulse.
  int m_count  = 0;
  int m_reload = 0;
  bit m_run    = 1'b0;
  bit m_pause  = 1'b0;
  bit m_done   = 1'b0;

  // tc as seen mid-cycle during the latest step, and what the model wanted.
  logic obs_tc;
  logic exp_tc;

  countdown_timer #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .enable   (enable),
    .count    (count),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Advance the model by one clock using the timer's rules written out
  // directly: load wins, then stop, then start, then the enable tick.
  function automatic void model_step(input bit l, input int lv, input bit st,
                                     input bit sp, input bit per, input bit en);
    bit nd;
    nd = 1'b0;
    if (l) begin
      m_count  = lv % (1 << W);
      m_reload = m_count;
      m_run    = 1'b0;
      m_pause  = 1'b0;
    end else if (sp) begin
      if (m_run) begin
        m_run   = 1'b0;
        m_pause = 1'b1;
      end
    end else if (st && !m_run && !m_pause) begin
      if (m_count != 0) m_run = 1'b1;
      else nd = 1'b1;
    end else if (st && m_pause) begin
      m_pause = 1'b0;
      m_run   = 1'b1;
    end else if (m_run && en) begin
      if (m_count == 1) begin
        nd = 1'b1;
        if (per) begin
          m_count = m_reload;
        end else begin
          m_count = 0;
          m_run   = 1'b0;
        end
      end else if (m_count > 1) begin
        m_count = m_count - 1;
      end
    end
    m_done = nd;
  endfunction

  function automatic void model_reset();
    m_count  = 0;
    m_reload = 0;
    m_run    = 1'b0;
    m_pause  = 1'b0;
    m_done   = 1'b0;
  endfunction

  // Drive one cycle of inputs just after a rising edge, sample tc mid-cycle,
  // then let the edge happen and move the model along with it.
  task automatic step(input bit l, input int lv, input bit st, input bit sp,
                      input bit per, input bit en);
    load     = l;
    load_val = lv[W-1:0];
    start    = st;
    stop     = sp;
    periodic = per;
    enable   = en;
    #2;
    obs_tc = tc;
    exp_tc = m_run && en && (m_count == 1);
    @(posedge clk);
    model_step(l, lv, st, sp, per, en);
    #1;
  endtask

  // Reset held from time zero: outputs must already be cleared before any
  // clock edge, then reset is released between edges.
  task automatic test_reset();
    reset    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    start    = 1'b0;
    stop     = 1'b0;
    periodic = 1'b0;
    enable   = 1'b0;
    #3;
    checks++;
    if ({count, busy, done, tc} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got count=%0d busy=%b done=%b tc=%b, expected 0 0 0 0",
               count, busy, done, tc);
    end
    #9;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({count, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_release: got count=%0d busy=%b done=%b, expected 0 0 0",
               count, busy, done);
    end
  endtask

  // Load 5, start, hold enable: count walks 4,3,2,1 then expiry. tc is high
  // while count is one; done rises the cycle busy falls.
  task automatic test_one_shot();
    int exp_cnt [6] = '{4, 3, 2, 1, 0, 0};
    bit exp_bsy [6] = '{1, 1, 1, 1, 0, 0};
    bit exp_dn  [6] = '{0, 0, 0, 0, 1, 0};
    bit exp_t   [6] = '{0, 0, 0, 0, 1, 0};
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({count, busy, done} !== {8'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL oneshot_start: got count=%0d busy=%b done=%b, expected 5 1 0",
               count, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if ({count, busy, done, obs_tc} !==
          {exp_cnt[i][W-1:0], exp_bsy[i], exp_dn[i], exp_t[i]}) begin
        errors++;
        $display("[TB] FAIL oneshot_step%0d: got count=%0d busy=%b done=%b tc=%b, expected %0d %b %b %b",
                 i, count, busy, done, obs_tc, exp_cnt[i], exp_bsy[i], exp_dn[i], exp_t[i]);
      end
    end
  endtask

  // Periodic reload of 3 with enable held: 2,1,3,2,1,3,... with done after
  // every reload and busy never dropping.
  task automatic test_periodic();
    int n_done;
    n_done = 0;
    step(1, 3, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 1, 1);
      if (done) n_done++;
      checks++;
      if ({count, busy, done, obs_tc} !== {m_count[W-1:0], 1'b1, m_done, exp_tc}) begin
        errors++;
        $display("[TB] FAIL periodic_step%0d: got count=%0d busy=%b done=%b tc=%b, expected %0d 1 %b %b",
                 i, count, busy, done, obs_tc, m_count, m_done, exp_tc);
      end
    end
    checks++;
    if (n_done != 3) begin
      errors++;
      $display("[TB] FAIL periodic_done_count: got %0d pulses, expected 3", n_done);
    end
    step(1, 0, 0, 0, 0, 0);
  endtask

  // Enable high one cycle in ten with a load of 2: the count only moves on
  // tick cycles and done appears after the second tick.
  task automatic test_sparse_ticks();
    int done_at;
    bit en;
    done_at = -1;
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      en = ((i % 10) == 9);
      step(0, 0, 0, 0, 0, en);
      if (done) done_at = i + 1;
      checks++;
      if ({count, busy, done} !== {m_count[W-1:0], m_run | m_pause, m_done}) begin
        errors++;
        $display("[TB] FAIL sparse_cycle%0d: got count=%0d busy=%b done=%b, expected %0d %b %b",
                 i, count, busy, done, m_count, m_run | m_pause, m_done);
      end
    end
    checks++;
    if (done_at != 20) begin
      errors++;
      $display("[TB] FAIL sparse_done_latency: got done after %0d cycles, expected 20", done_at);
    end
  endtask

  // Pause at 3 while enable keeps ticking, resume with start, then check
  // that start and stop together in RUN and in PAUSE both leave it paused.
  task automatic test_pause_resume();
    step(1, 6, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if ({count, busy, done} !== {8'd3, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL pause_hold%0d: got count=%0d busy=%b done=%b, expected 3 1 0",
                 i, count, busy, done);
      end
    end
    step(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if ({count, busy, done, obs_tc} !== {m_count[W-1:0], m_run | m_pause, m_done, exp_tc}) begin
        errors++;
        $display("[TB] FAIL resume_step%0d: got count=%0d busy=%b done=%b tc=%b, expected %0d %b %b %b",
                 i, count, busy, done, obs_tc, m_count, m_run | m_pause, m_done, exp_tc);
      end
    end
    step(1, 4, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if ({count, busy, m_pause} !== {8'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL start_stop_run: got count=%0d busy=%b, expected 3 1 (paused)",
               count, busy);
    end
    step(0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if ({count, busy} !== {8'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL start_stop_pause: got count=%0d busy=%b, expected 3 1", count, busy);
    end
    step(1, 0, 0, 0, 0, 0);
  endtask

  // Reload mid-run at count 2 and at count 1 with a tick pending; neither
  // may produce done. Then a zero-start must give exactly one done pulse.
  task automatic test_load_zero_start();
    step(1, 7, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
    step(1, 7, 0, 0, 0, 1);
    checks++;
    if ({count, busy, done} !== {8'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL load_midrun: got count=%0d busy=%b done=%b, expected 7 0 0",
               count, busy, done);
    end
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
    step(1, 9, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if ({count, busy, done} !== {8'd9, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL load_discards_expiry: got count=%0d busy=%b done=%b, expected 9 0 0",
               count, busy, done);
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({count, busy, done} !== {8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL zero_start: got count=%0d busy=%b done=%b, expected 0 0 1",
               count, busy, done);
    end
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if ({count, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL zero_start_single: got count=%0d busy=%b done=%b, expected 0 0 0",
               count, busy, done);
    end
  endtask

  // Pull reset low between clock edges, once mid-run at count 4 and once
  // while done is high; outputs must clear without waiting for an edge.
  task automatic test_reset_midrun();
    step(1, 8, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    checks++;
    if (count !== 8'd4) begin
      errors++;
      $display("[TB] FAIL reset_setup: got count=%0d, expected 4", count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({count, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_midrun: got count=%0d busy=%b done=%b, expected 0 0 0",
               count, busy, done);
    end
    #3;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({count, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_clears_done: got count=%0d busy=%b done=%b, expected 0 0 0",
               count, busy, done);
    end
    #3;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Random mix of every control, each cycle compared with the model.
  task automatic test_random();
    bit l, st, sp, per, en;
    int lv;
    for (int i = 0; i < 600; i++) begin
      l   = ($urandom_range(0, 15) == 0);
      st  = ($urandom_range(0, 3) == 0);
      sp  = ($urandom_range(0, 7) == 0);
      per = $urandom_range(0, 1);
      en  = $urandom_range(0, 1);
      lv  = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 6);
      step(l, lv, st, sp, per, en);
      checks++;
      if ({count, busy, done, obs_tc} !== {m_count[W-1:0], m_run | m_pause, m_done, exp_tc}) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got count=%0d busy=%b done=%b tc=%b, expected %0d %b %b %b",
                 i, count, busy, done, obs_tc, m_count, m_run | m_pause, m_done, exp_tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_sparse_ticks();
    test_pause_resume();
    test_load_zero_start();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
